// File: rtl/rename_unit.sv
// ============================================================================
// Module   : rename_unit
// Purpose  : Register rename stage. Maps architectural rs1/rs2/rd onto physical
//            tags through a speculative RAT and allocates destination tags from
//            a circular free list that the ROB refills at retire.
//            Optional macro RENAME_DOUBLE_FREE_CHECK_EN adds double-free detection.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rename_unit #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PTAG_W    = 6,
    parameter int FL_DEPTH  = PHYS_REGS - ARCH_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id2rn_valid,
    input  logic [4:0]        id2rn_rs1,
    input  logic [4:0]        id2rn_rs2,
    input  logic [4:0]        id2rn_rd,
    input  logic              id2rn_reg_write,
    input  logic              iq2rn_full,
    input  logic              rob2rn_free_valid,
    input  logic [PTAG_W-1:0] rob2rn_free_tag,
    output logic              rn2id_stall,
    output logic              rn2iq_valid,
    output logic [PTAG_W-1:0] rn2iq_rs1_p,
    output logic [PTAG_W-1:0] rn2iq_rs2_p,
    output logic [PTAG_W-1:0] rn2iq_rd_p,
    output logic [PTAG_W-1:0] rn2rob_old_rd_p,
    output logic [4:0]        rn2rob_rd_arch,
`ifdef RENAME_DOUBLE_FREE_CHECK_EN
    output logic              rn_err_double_free,
`endif
    output logic [5:0]        rn_free_count
);

    localparam int              PTR_W     = $clog2(FL_DEPTH);
    localparam logic [5:0]      C_FL_FULL = 6'(FL_DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

    logic [PTAG_W-1:0] r_rat [ARCH_REGS];
    logic [PTAG_W-1:0] r_fl  [FL_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [5:0]        r_count;

    logic              w_need_alloc;
    logic              w_accept;
    logic              w_alloc;
    logic              w_free;
    logic              w_free_nz;
    logic              w_dup;
    logic [PTAG_W-1:0] w_new_tag;
    logic [PTAG_W-1:0] w_rs1_p;
    logic [PTAG_W-1:0] w_rs2_p;
    logic [PTAG_W-1:0] w_old_rd_p;

    assign w_need_alloc = id2rn_reg_write && (id2rn_rd != 5'd0);
    assign rn2id_stall  = iq2rn_full || (w_need_alloc && (r_count == 6'd0));
    assign w_accept     = id2rn_valid && !rn2id_stall;
    assign w_alloc      = w_accept && w_need_alloc;

    // RAT lookups happen before this cycle's write, so rs == rd sees the old tag
    assign w_rs1_p    = r_rat[id2rn_rs1];
    assign w_rs2_p    = r_rat[id2rn_rs2];
    assign w_old_rd_p = r_rat[id2rn_rd];
    assign w_new_tag  = r_fl[r_head];

    assign w_free_nz  = rob2rn_free_valid && (rob2rn_free_tag != '0);

`ifdef RENAME_DOUBLE_FREE_CHECK_EN
    logic [PHYS_REGS-1:0] r_in_fl;
    logic                 r_err_double_free;

    assign w_dup              = w_free_nz && r_in_fl[rob2rn_free_tag];
    assign rn_err_double_free = r_err_double_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHYS_REGS; i++) begin
                r_in_fl[i] <= (i >= ARCH_REGS);
            end
            r_err_double_free <= 1'b0;
        end else begin
            if (w_alloc) begin
                r_in_fl[w_new_tag] <= 1'b0;
            end
            // A duplicate is dropped, so it can never collide with the alloc clear
            if (w_free) begin
                r_in_fl[rob2rn_free_tag] <= 1'b1;
            end
            if (w_dup) begin
                r_err_double_free <= 1'b1;
            end
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // Tag 0 and frees into a full list are silently discarded
    assign w_free = w_free_nz && (r_count != C_FL_FULL) && !w_dup;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_rat[i] <= PTAG_W'(i);
            end
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_fl[i] <= PTAG_W'(ARCH_REGS + i);
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= C_FL_FULL;
        end else begin
            if (w_alloc) begin
                r_rat[id2rn_rd] <= w_new_tag;
                r_head          <= r_head + C_PTR_ONE;
            end
            if (w_free) begin
                r_fl[r_tail] <= rob2rn_free_tag;
                r_tail       <= r_tail + C_PTR_ONE;
            end
            case ({w_alloc, w_free})
                2'b10:   r_count <= r_count - 6'd1;
                2'b01:   r_count <= r_count + 6'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rn2iq_valid     <= 1'b0;
            rn2iq_rs1_p     <= '0;
            rn2iq_rs2_p     <= '0;
            rn2iq_rd_p      <= '0;
            rn2rob_old_rd_p <= '0;
            rn2rob_rd_arch  <= '0;
        end else begin
            rn2iq_valid <= w_accept;
            if (w_accept) begin
                rn2iq_rs1_p     <= w_rs1_p;
                rn2iq_rs2_p     <= w_rs2_p;
                rn2iq_rd_p      <= w_need_alloc ? w_new_tag  : '0;
                rn2rob_old_rd_p <= w_need_alloc ? w_old_rd_p : '0;
                rn2rob_rd_arch  <= id2rn_rd;
            end
        end
    end

    assign rn_free_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rename_unit.sv
// ============================================================================
// Module   : tb_rename_unit
// Purpose  : Directed self-checking bench for rename_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rename_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id2rn_valid = 1'b0;
    logic [4:0] id2rn_rs1 = '0;
    logic [4:0] id2rn_rs2 = '0;
    logic [4:0] id2rn_rd = '0;
    logic       id2rn_reg_write = 1'b0;
    logic       iq2rn_full = 1'b0;
    logic       rob2rn_free_valid = 1'b0;
    logic [5:0] rob2rn_free_tag = '0;
    logic       rn2id_stall;
    logic       rn2iq_valid;
    logic [5:0] rn2iq_rs1_p;
    logic [5:0] rn2iq_rs2_p;
    logic [5:0] rn2iq_rd_p;
    logic [5:0] rn2rob_old_rd_p;
    logic [4:0] rn2rob_rd_arch;
    logic [5:0] rn_free_count;
`ifdef RENAME_DOUBLE_FREE_CHECK_EN
    logic       rn_err_double_free;
`endif

    int total = 0;
    int bad   = 0;

    rename_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id2rn_valid       (id2rn_valid),
        .id2rn_rs1         (id2rn_rs1),
        .id2rn_rs2         (id2rn_rs2),
        .id2rn_rd          (id2rn_rd),
        .id2rn_reg_write   (id2rn_reg_write),
        .iq2rn_full        (iq2rn_full),
        .rob2rn_free_valid (rob2rn_free_valid),
        .rob2rn_free_tag   (rob2rn_free_tag),
        .rn2id_stall       (rn2id_stall),
        .rn2iq_valid       (rn2iq_valid),
        .rn2iq_rs1_p       (rn2iq_rs1_p),
        .rn2iq_rs2_p       (rn2iq_rs2_p),
        .rn2iq_rd_p        (rn2iq_rd_p),
        .rn2rob_old_rd_p   (rn2rob_old_rd_p),
        .rn2rob_rd_arch    (rn2rob_rd_arch),
`ifdef RENAME_DOUBLE_FREE_CHECK_EN
        .rn_err_double_free(rn_err_double_free),
`endif
        .rn_free_count     (rn_free_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw);
        id2rn_valid     = v;
        id2rn_rs1       = rs1;
        id2rn_rs2       = rs2;
        id2rn_rd        = rd;
        id2rn_reg_write = rw;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        iq2rn_full        = 1'b0;
        rob2rn_free_valid = 1'b0;
        rob2rn_free_tag   = '0;
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", rn2iq_valid, 0);
        check("rst_rs1", rn2iq_rs1_p, 0);
        check("rst_rd", rn2iq_rd_p, 0);
        check("rst_old", rn2rob_old_rd_p, 0);
        check("rst_count", rn_free_count, 32);
        check("rst_stall", rn2id_stall, 0);
`ifdef RENAME_DOUBLE_FREE_CHECK_EN
        check("rst_err", rn_err_double_free, 0);
`endif

        // add x3,x1,x2
        drive(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("add_valid", rn2iq_valid, 1);
        check("add_rs1", rn2iq_rs1_p, 1);
        check("add_rs2", rn2iq_rs2_p, 2);
        check("add_rd", rn2iq_rd_p, 32);
        check("add_old", rn2rob_old_rd_p, 3);
        check("add_arch", rn2rob_rd_arch, 3);
        check("add_count", rn_free_count, 31);

        // Back-to-back dependent instructions
        do_reset();
        drive(1'b1, 5'd3, 5'd3, 5'd3, 1'b1);
        step();
        drive(1'b1, 5'd3, 5'd3, 5'd4, 1'b1);
        check("b2b1_rs1", rn2iq_rs1_p, 3);
        check("b2b1_rs2", rn2iq_rs2_p, 3);
        check("b2b1_rd", rn2iq_rd_p, 32);
        check("b2b1_old", rn2rob_old_rd_p, 3);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("b2b2_rs1", rn2iq_rs1_p, 32);
        check("b2b2_rs2", rn2iq_rs2_p, 32);
        check("b2b2_rd", rn2iq_rd_p, 33);
        check("b2b2_old", rn2rob_old_rd_p, 4);
        check("b2b2_count", rn_free_count, 30);
        step();
        check("idle_valid", rn2iq_valid, 0);
        check("idle_hold_rd", rn2iq_rd_p, 33);

        // Exhaust the free list with writes to x5
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
            step();
            check("x5_rd", rn2iq_rd_p, 64'(32 + i));
        end
        check("x5_old", rn2rob_old_rd_p, 62);
        check("empty_count", rn_free_count, 0);
        check("empty_stall", rn2id_stall, 1);
        step();
        check("empty_valid", rn2iq_valid, 0);
        rob2rn_free_valid = 1'b1;
        rob2rn_free_tag   = 6'd5;
        #1;
        check("free_stall", rn2id_stall, 1);
        step();
        rob2rn_free_valid = 1'b0;
        check("free_valid_out", rn2iq_valid, 0);
        check("free_count", rn_free_count, 1);
        check("free_unstall", rn2id_stall, 0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("reuse_valid", rn2iq_valid, 1);
        check("reuse_rd", rn2iq_rd_p, 5);
        check("reuse_old", rn2rob_old_rd_p, 63);
        check("reuse_count", rn_free_count, 0);

        // x0 writes, stores, free of tag 0, issue-queue backpressure
        do_reset();
        drive(1'b1, 5'd7, 5'd9, 5'd0, 1'b1);
        step();
        check("x0_valid", rn2iq_valid, 1);
        check("x0_rs1", rn2iq_rs1_p, 7);
        check("x0_rs2", rn2iq_rs2_p, 9);
        check("x0_rd", rn2iq_rd_p, 0);
        check("x0_old", rn2rob_old_rd_p, 0);
        check("x0_count", rn_free_count, 32);
        drive(1'b1, 5'd6, 5'd1, 5'd6, 1'b0);
        step();
        check("st_rs1", rn2iq_rs1_p, 6);
        check("st_rd", rn2iq_rd_p, 0);
        check("st_old", rn2rob_old_rd_p, 0);
        check("st_arch", rn2rob_rd_arch, 6);
        check("st_count", rn_free_count, 32);
        drive(1'b1, 5'd1, 5'd1, 5'd3, 1'b1);
        step();
        check("x3_rd", rn2iq_rd_p, 32);
        check("x3_count", rn_free_count, 31);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        rob2rn_free_valid = 1'b1;
        rob2rn_free_tag   = 6'd0;
        step();
        rob2rn_free_valid = 1'b0;
        check("free0_count", rn_free_count, 31);
        iq2rn_full = 1'b1;
        drive(1'b1, 5'd3, 5'd2, 5'd8, 1'b1);
        #1;
        check("full_stall", rn2id_stall, 1);
        step();
        check("full_valid", rn2iq_valid, 0);
        check("full_count", rn_free_count, 31);
        iq2rn_full = 1'b0;
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("unfull_valid", rn2iq_valid, 1);
        check("unfull_rs1", rn2iq_rs1_p, 32);
        check("unfull_rd", rn2iq_rd_p, 33);
        check("unfull_old", rn2rob_old_rd_p, 8);
        check("unfull_count", rn_free_count, 30);
        rob2rn_free_valid = 1'b1;
        rob2rn_free_tag   = 6'd8;
        step();
        rob2rn_free_valid = 1'b0;
        check("free8_count", rn_free_count, 31);

        // Free of a tag already in the list at reset
        do_reset();
        rob2rn_free_valid = 1'b1;
        rob2rn_free_tag   = 6'd40;
        step();
        rob2rn_free_valid = 1'b0;
        check("dbl_count", rn_free_count, 32);
`ifdef RENAME_DOUBLE_FREE_CHECK_EN
        check("dbl_err", rn_err_double_free, 1);
        step();
        check("dbl_err_sticky", rn_err_double_free, 1);
`endif
        // First allocation after the dropped free must still be tag 32
        drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        check("dbl_alloc_rd", rn2iq_rd_p, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- Register rename stage that sits directly upstream of the issue queue.
- Maps architectural rs1/rs2/rd (x0-x31) to physical tags p0-p63 through a speculative register alias table (RAT), and allocates new destination tags from a circular free list.
- Returns tags to the free list when the ROB retires an instruction.
- Delivers registered source and destination tags, plus the previous rd mapping, to the issue queue and ROB with one-cycle latency.

Parameters:
- ARCH_REGS, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers.
- PTAG_W, 6, physical tag width (log2 PHYS_REGS).
- FL_DEPTH, 32, free-list capacity (PHYS_REGS - ARCH_REGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id2rn_valid  in  1  decoded instruction present.
- id2rn_rs1  in  5  architectural source 1.
- id2rn_rs2  in  5  architectural source 2.
- id2rn_rd  in  5  architectural destination.
- id2rn_reg_write  in  1  instruction writes rd.
- iq2rn_full  in  1  issue queue full (queue_full).
- rob2rn_free_valid  in  1  retiring instruction releases a tag.
- rob2rn_free_tag  in  PTAG_W  tag being released (old rd mapping).
- rn2id_stall  out  1  rename cannot accept this cycle.
- rn2iq_valid  out  1  renamed instruction valid.
- rn2iq_rs1_p  out  PTAG_W  physical rs1.
- rn2iq_rs2_p  out  PTAG_W  physical rs2.
- rn2iq_rd_p  out  PTAG_W  physical rd (0 when no write).
- rn2rob_old_rd_p  out  PTAG_W  previous mapping of rd, to be freed at retire.
- rn2rob_rd_arch  out  5  architectural rd.
- rn_free_count  out  6  tags currently in the free list (0..32).

Behaviour:
- Clock and reset: one clock domain. rst_n is asynchronous and active-low.
- Reset state of the RAT: RAT[i] = i for i = 0..31.
- Reset state of the free list: holds tags 32..63 in ascending order; head = 0, tail = 0 (wrapped), count = 32.
- Reset value of outputs: all rn2iq_*/rn2rob_* = 0; rn2iq_valid = 0; rn_free_count = 32.
- need_alloc = id2rn_reg_write && (id2rn_rd != 0).
- rn2id_stall (combinational) = iq2rn_full || (need_alloc && count == 0).
- accept = id2rn_valid && !rn2id_stall.
- On accept, in the same cycle:
  - Read RAT[rs1] and RAT[rs2] before the update, so rs == rd yields the old mapping.
  - If need_alloc: new tag = fl[head]; head advances mod 32; RAT[rd] <= new tag; old_rd_p = RAT[rd].
  - If not need_alloc: rd_p = 0 and old_rd_p = 0; no allocation.
- Output register: on the clock edge after accept, rn2iq_valid = 1 with the tags. Otherwise rn2iq_valid = 0 and the data fields hold their last values.
- Latency: exactly 1 cycle; the outputs feed the issue queue's allocation inputs directly.
- Back-to-back instructions: the RAT write is visible to the next cycle's lookup, so dependent instructions get the new tag.
- x0: RAT[0] is pinned to p0 and is never written or allocated. A free of tag 0 is ignored.
- Free: when rob2rn_free_valid and tag != 0, write fl[tail] <= tag and advance tail mod 32.
- Simultaneous alloc and free: count unchanged. The freed tag is not bypassed to the allocation in the same cycle. If count == 0, the stall still asserts that cycle.
- A free arriving when count == 32 is a protocol violation. The tag is dropped and count saturates at 32.
- Pointers are 5-bit and wrap 31 -> 0. The count register disambiguates full from empty.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); any in-flight output is discarded.

Optional Feature:
- Macro RENAME_DOUBLE_FREE_CHECK_EN.
- When defined:
  - Adds a 64-bit in_free_list vector (reset: bits 32..63 set).
  - Adds output rn_err_double_free (1 bit, reset 0).
  - A free of a tag whose bit is already set is dropped, not pushed, and sets rn_err_double_free sticky until reset.
  - Allocation clears the allocated tag's bit; a valid free sets it.
- When not defined: no vector, no port, no checking.

Test Plan:
- Reset, then accept add x3,x1,x2 -> next cycle rs1_p=1, rs2_p=2, rd_p=32, old_rd_p=3, rn_free_count=31.
- Back-to-back add x3,x3,x3 then add x4,x3,x3 -> first: rs1_p=rs2_p=3, rd_p=32. Second: rs1_p=rs2_p=32, rd_p=33.
- Thirty-three writes of x5 with no frees -> the 33rd holds rn2id_stall=1 and rn2iq_valid=0. A free of tag 5 then lets it issue next with rd_p=5.
- Write to x0 and a store (reg_write=0) -> rd_p=0, old_rd_p=0, count unchanged. A free of tag 0 leaves count unchanged.
- iq2rn_full=1 with id2rn_valid=1 -> stall=1 and no RAT or free-list change. Deassert -> renames normally next cycle.
- With RENAME_DOUBLE_FREE_CHECK_EN, free tag 40 at reset -> rn_err_double_free=1 and count stays 32. Without the macro, the same stimulus leaves count at 32 (drop on full).
